// File: rtl/axi_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axi_bus_bridge
// Purpose  : Bridges the CPU core's two SRAM-style request/addr_ok/data_ok
//            channels (instruction fetch, data load/store) onto a single-beat
//            AXI master interface. One transaction is in flight at a time.
//            Data requests take priority over instruction requests.
//
//            The AXI attributes that never change are not ports. These are
//            len=0, size=2 (4 bytes), burst=INCR, id=0 and wlast=1. The
//            response codes are not examined. The interconnect wrapper ties
//            them.
//
// Ports    :
//   clk_i, resetn_i          clock, asynchronous active-low reset
//   inst_req_i/inst_addr_i   fetch request; inst_addr_ok_o accepts it
//   inst_data_ok_o/_rdata_o  fetch data return (one-cycle pulse)
//   data_req_i/_wr_i/...     load/store request; data_addr_ok_o accepts it
//   data_data_ok_o/_rdata_o  load data return / store completion
//   ar*/r*                   AXI read address / read data channels
//   aw*/w*/b*                AXI write address / write data / response
//
// Revision : 1.0 - initial release
// ============================================================================
module axi_bus_bridge #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  // Instruction channel (read-only)
  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic              inst_addr_ok_o,
  output logic              inst_data_ok_o,
  output logic [31:0]       inst_rdata_o,
  // Data channel
  input  logic              data_req_i,
  input  logic              data_wr_i,
  input  logic [3:0]        data_wstrb_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [31:0]       data_wdata_i,
  output logic              data_addr_ok_o,
  output logic              data_data_ok_o,
  output logic [31:0]       data_rdata_o,
  // AXI read address / data
  output logic [ADDR_W-1:0] araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [31:0]       rdata_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  // AXI write address / data / response
  output logic [ADDR_W-1:0] awaddr_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [31:0]       wdata_o,
  output logic [3:0]        wstrb_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic              bvalid_i,
  output logic              bready_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW_W = 3'd3,
    ST_B    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              wr_q,    wr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;
  // 1 = transaction belongs to the data channel, 0 = instruction channel
  logic              src_data_q, src_data_d;
  // Write address and write data handshake independently, so each has a flag
  logic              aw_done_q, aw_done_d;
  logic              w_done_q,  w_done_d;

  // --------------------------------------------------------------------------
  // State and latched request
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wstrb_q    <= 4'b0000;
      wdata_q    <= 32'h0;
      src_data_q <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      src_data_q <= src_data_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wr_d           = wr_q;
    wstrb_d        = wstrb_q;
    wdata_d        = wdata_q;
    src_data_d     = src_data_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;

    inst_addr_ok_o = 1'b0;
    inst_data_ok_o = 1'b0;
    data_addr_ok_o = 1'b0;
    data_data_ok_o = 1'b0;
    arvalid_o      = 1'b0;
    rready_o       = 1'b0;
    awvalid_o      = 1'b0;
    wvalid_o       = 1'b0;
    bready_o       = 1'b0;

    // Address/data buses always show the latched request. Read data passes
    // straight through. Its value only matters while the matching ok is high.
    araddr_o       = addr_q;
    awaddr_o       = addr_q;
    wdata_o        = wdata_q;
    wstrb_o        = wstrb_q;
    inst_rdata_o   = rdata_i;
    data_rdata_o   = rdata_i;

    unique case (state_q)
      ST_IDLE: begin
        // The addr_ok outputs are combinational from the request inputs. They
        // are gated by reset so that none is seen while the bridge is held
        // in reset.
        if (resetn_i && data_req_i) begin
          data_addr_ok_o = 1'b1;
          addr_d         = data_addr_i;
          wr_d           = data_wr_i;
          wstrb_d        = data_wstrb_i;
          wdata_d        = data_wdata_i;
          src_data_d     = 1'b1;
          state_d        = data_wr_i ? ST_AW_W : ST_AR;
        end else if (resetn_i && inst_req_i) begin
          inst_addr_ok_o = 1'b1;
          addr_d         = inst_addr_i;
          wr_d           = 1'b0;
          wstrb_d        = 4'b0000;
          wdata_d        = 32'h0;
          src_data_d     = 1'b0;
          state_d        = ST_AR;
        end
      end

      ST_AR: begin
        arvalid_o = 1'b1;
        if (arready_i) begin
          state_d = ST_R;
        end
      end

      ST_R: begin
        rready_o = 1'b1;
        if (rvalid_i) begin
          if (src_data_q) begin
            data_data_ok_o = 1'b1;
          end else begin
            inst_data_ok_o = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end

      ST_AW_W: begin
        awvalid_o = !aw_done_q;
        wvalid_o  = !w_done_q;
        // Fold this cycle's handshakes into the flags. The B phase then
        // starts right after the later of the two handshakes. This also
        // covers both completing in the same cycle.
        aw_done_d = aw_done_q | (!aw_done_q & awready_i);
        w_done_d  = w_done_q  | (!w_done_q  & wready_i);
        if (aw_done_d && w_done_d) begin
          state_d = ST_B;
        end
      end

      ST_B: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          // Stores complete only on the data channel.
          data_data_ok_o = 1'b1;
          aw_done_d      = 1'b0;
          w_done_d       = 1'b0;
          state_d        = ST_IDLE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_bus_bridge
// Purpose  : Self-checking bench for axi_bus_bridge. A core-side driver holds
//            requests until they are accepted. A word-addressed AXI slave
//            with per-transaction wait states answers the bridge. A
//            transaction-level reference model predicts every handshake
//            output, read data and completion latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_bus_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  axi_bus_bridge #(.ADDR_W(32)) dut (
    .clk_i(clk), .resetn_i(resetn),
    .inst_req_i(inst_req), .inst_addr_i(inst_addr),
    .inst_addr_ok_o(inst_addr_ok), .inst_data_ok_o(inst_data_ok),
    .inst_rdata_o(inst_rdata),
    .data_req_i(data_req), .data_wr_i(data_wr), .data_wstrb_i(data_wstrb),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_addr_ok_o(data_addr_ok), .data_data_ok_o(data_data_ok),
    .data_rdata_o(data_rdata),
    .araddr_o(araddr), .arvalid_o(arvalid), .arready_i(arready),
    .rdata_i(rdata), .rvalid_i(rvalid), .rready_o(rready),
    .awaddr_o(awaddr), .awvalid_o(awvalid), .awready_i(awready),
    .wdata_o(wdata), .wstrb_o(wstrb), .wvalid_o(wvalid), .wready_i(wready),
    .bvalid_i(bvalid), .bready_o(bready)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Pending core requests (held until accepted)
  bit          pd_v, pd_wr, pi_v;
  logic [31:0] pd_addr, pd_wdata, pi_addr;
  logic [3:0]  pd_wstrb;

  // The single outstanding transaction, as the model sees it
  bit          out_v, out_src, out_wr;
  logic [31:0] out_addr, out_wdata, exp_rdata;
  logic [3:0]  out_wstrb;
  int          acc_cyc, exp_lat;
  bit          ar_got, aw_got, w_got;

  // Slave wait states and their counters
  int ar_w, r_w, aw_w, w_w, b_w;
  int ar_c, r_c, aw_c, w_c, b_c;
  bit rand_waits;
  int gen_left;
  int n_acc, n_ok;

  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  function automatic logic [31:0] seed_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : seed_word(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_txn();
    out_v  = 1'b0;
    ar_got = 1'b0; aw_got = 1'b0; w_got = 1'b0;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
  endtask

  // Applies core and slave inputs for the current cycle (called just after posedge)
  task automatic drive();
    if (gen_left > 0 && !pd_v && $urandom_range(0, 2) == 0) begin
      pd_v     = 1'b1;
      pd_wr    = 1'($urandom_range(0, 1));
      pd_addr  = 32'h8000_0000 + ($urandom_range(0, 15) << 2);
      pd_wdata = $urandom;
      pd_wstrb = 4'($urandom_range(0, 15));
      gen_left--;
    end
    if (gen_left > 0 && !pi_v && $urandom_range(0, 2) == 0) begin
      pi_v    = 1'b1;
      pi_addr = 32'h8000_0000 + ($urandom_range(0, 15) << 2);
      gen_left--;
    end
    data_req   = pd_v;
    data_wr    = pd_wr;
    data_addr  = pd_addr;
    data_wdata = pd_wdata;
    data_wstrb = pd_wstrb;
    inst_req   = pi_v;
    inst_addr  = pi_addr;
    arready = (arvalid === 1'b1) && (ar_c >= ar_w);
    rvalid  = (rready  === 1'b1) && (r_c  >= r_w);
    rdata   = rvalid ? slv_rd(cap_araddr) : $urandom;
    awready = (awvalid === 1'b1) && (aw_c >= aw_w);
    wready  = (wvalid  === 1'b1) && (w_c  >= w_w);
    bvalid  = (bready  === 1'b1) && (b_c  >= b_w);
  endtask

  task automatic accept(input bit is_data);
    out_v     = 1'b1;
    out_src   = is_data;
    out_wr    = is_data ? pd_wr : 1'b0;
    out_addr  = is_data ? pd_addr : pi_addr;
    out_wdata = pd_wdata;
    out_wstrb = pd_wstrb;
    acc_cyc   = cyc;
    n_acc++;
    if (is_data) pd_v = 1'b0; else pi_v = 1'b0;
    if (rand_waits) begin
      ar_w = $urandom_range(0, 3); r_w = $urandom_range(0, 3);
      aw_w = $urandom_range(0, 3); w_w = $urandom_range(0, 3);
      b_w  = $urandom_range(0, 3);
    end
    if (out_wr) begin
      exp_lat = 2 + ((aw_w > w_w) ? aw_w : w_w) + b_w;
      ref_mem[out_addr] = merge(ref_rd(out_addr), out_wdata, out_wstrb);
    end else begin
      exp_lat   = 2 + ar_w + r_w;
      exp_rdata = ref_rd(out_addr);
    end
  endtask

  // One clock: check at negedge, update model, then drive the next inputs
  task automatic step();
    bit e_daok, e_iaok, e_arv, e_rr, e_awv, e_wv, e_br, compl;
    @(negedge clk);
    cyc++;
    e_daok = resetn && !out_v && pd_v;
    e_iaok = resetn && !out_v && !pd_v && pi_v;
    e_arv  = out_v && !out_wr && !ar_got;
    e_rr   = out_v && !out_wr && ar_got;
    e_awv  = out_v && out_wr && !aw_got;
    e_wv   = out_v && out_wr && !w_got;
    e_br   = out_v && out_wr && aw_got && w_got;
    compl  = (e_rr && rvalid) || (e_br && bvalid);

    chk("data_addr_ok", data_addr_ok, e_daok);
    chk("inst_addr_ok", inst_addr_ok, e_iaok);
    chk("arvalid", arvalid, e_arv);
    chk("rready", rready, e_rr);
    chk("awvalid", awvalid, e_awv);
    chk("wvalid", wvalid, e_wv);
    chk("bready", bready, e_br);
    chk("inst_data_ok", inst_data_ok, compl && !out_src);
    chk("data_data_ok", data_data_ok, compl && out_src);
    if (e_arv) chk("araddr", araddr, out_addr);
    if (e_awv) chk("awaddr", awaddr, out_addr);
    if (e_wv) begin
      chk("wdata", wdata, out_wdata);
      chk("wstrb", {28'h0, wstrb}, {28'h0, out_wstrb});
    end
    if (compl && !out_src) chk("inst_rdata", inst_rdata, exp_rdata);
    if (compl && out_src && !out_wr) chk("data_rdata", data_rdata, exp_rdata);
    if (compl) chk("latency", cyc - acc_cyc, exp_lat);

    // Slave-side bookkeeping from what the bus actually did
    if (arvalid === 1'b1 && arready === 1'b1) begin
      ar_got = out_v && !out_wr; cap_araddr = araddr; ar_c = 0;
    end else if (arvalid === 1'b1) ar_c++;
    if (rready === 1'b1 && rvalid !== 1'b1) r_c++;
    if (awvalid === 1'b1 && awready === 1'b1) begin
      aw_got = out_v && out_wr; cap_awaddr = awaddr; aw_c = 0;
    end else if (awvalid === 1'b1) aw_c++;
    if (wvalid === 1'b1 && wready === 1'b1) begin
      w_got = out_v && out_wr; cap_wdata = wdata; cap_wstrb = wstrb; w_c = 0;
    end else if (wvalid === 1'b1) w_c++;
    if (bready === 1'b1 && bvalid !== 1'b1) b_c++;
    if (bready === 1'b1 && bvalid === 1'b1)
      slv_mem[cap_awaddr] = merge(slv_rd(cap_awaddr), cap_wdata, cap_wstrb);

    if (compl) begin
      clear_txn();
      n_ok++;
    end else if (out_v && (cyc - acc_cyc > 60)) begin
      chk("txn_timeout", cyc - acc_cyc, exp_lat);
      clear_txn();
      n_acc--;
    end
    if (e_daok) accept(1'b1);
    else if (e_iaok) accept(1'b0);

    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (!out_v && !pd_v && !pi_v && gen_left == 0) break;
      step();
    end
    chk("drained", {31'h0, out_v | pd_v | pi_v}, 32'h0);
  endtask

  initial begin
    resetn = 1'b0;
    pd_v = 0; pd_wr = 0; pi_v = 0;
    pd_addr = 0; pd_wdata = 0; pd_wstrb = 0; pi_addr = 0;
    ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
    rand_waits = 0; gen_left = 0; n_acc = 0; n_ok = 0;
    cap_araddr = 0; cap_awaddr = 0; cap_wdata = 0; cap_wstrb = 0;
    exp_rdata = 0; exp_lat = 0; acc_cyc = 0;
    out_src = 0; out_wr = 0; out_addr = 0; out_wdata = 0; out_wstrb = 0;
    clear_txn();
    drive();

    // Reset state
    repeat (3) step();
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_awaddr", awaddr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_wstrb", {28'h0, wstrb}, 32'h0);
    resetn = 1'b1;

    // Single load, zero-wait slave
    ref_mem[32'h1FC0_0010] = 32'hDEAD_BEEF;
    slv_mem[32'h1FC0_0010] = 32'hDEAD_BEEF;
    pd_v = 1; pd_wr = 0; pd_addr = 32'h1FC0_0010;
    drive();
    run_idle(20);

    // Store with back-pressure: wready at T1, awready at T3, bvalid at T5
    aw_w = 2; w_w = 0; b_w = 1;
    pd_v = 1; pd_wr = 1; pd_addr = 32'h8000_0004; pd_wdata = 32'h1234_5678; pd_wstrb = 4'b0011;
    drive();
    run_idle(20);
    aw_w = 0; b_w = 0;

    // Read back the partially written word
    pd_v = 1; pd_wr = 0; pd_addr = 32'h8000_0004;
    drive();
    run_idle(20);

    // Store with no byte enables still goes out on AXI
    pd_v = 1; pd_wr = 1; pd_addr = 32'h8000_0008; pd_wdata = 32'hFFFF_FFFF; pd_wstrb = 4'b0000;
    drive();
    run_idle(20);

    // Contention: data wins, fetch accepted in the next idle cycle
    pd_v = 1; pd_wr = 0; pd_addr = 32'h8000_0020;
    pi_v = 1; pi_addr = 32'h1FC0_0100;
    drive();
    run_idle(30);

    // Read wait states on the fetch channel
    ar_w = 3; r_w = 2;
    pi_v = 1; pi_addr = 32'h1FC0_0200;
    drive();
    run_idle(30);

    // Reset while waiting for read data
    ar_w = 0; r_w = 6;
    pd_v = 1; pd_wr = 0; pd_addr = 32'h8000_0030;
    drive();
    repeat (3) step();
    #1 resetn = 1'b0;
    #1;
    chk("arst_rready", rready, 1'b0);
    chk("arst_arvalid", arvalid, 1'b0);
    chk("arst_data_ok", {30'h0, data_data_ok, inst_data_ok}, 32'h0);
    chk("arst_addr_ok", {30'h0, data_addr_ok, inst_addr_ok}, 32'h0);
    chk("arst_wr_ch", {29'h0, awvalid, wvalid, bready}, 32'h0);
    clear_txn();
    n_acc--;
    pd_v = 0; pi_v = 0;
    drive();
    repeat (2) step();
    resetn = 1'b1;
    r_w = 0;
    pd_v = 1; pd_wr = 0; pd_addr = 32'h8000_0034;
    drive();
    run_idle(20);

    // Randomised traffic with random wait states
    rand_waits = 1;
    gen_left   = 300;
    run_idle(20000);

    chk("ok_pulse_count", n_ok, n_acc);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
